// File: rtl/clint_timer.sv
// Core-local interruptor: free-running 64-bit mtime, mtimecmp and msip behind a
// single-cycle request/response bus, producing the timer and software interrupt levels.
module clint_timer #(
  parameter int unsigned   TICK_DIV  = 1,
  parameter logic [15:0]   BASE_MASK = 16'hFFFF
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        timer_irq,
  output logic        sw_irq
);

  localparam logic [15:0] A_MSIP    = 16'h0000;
  localparam logic [15:0] A_CMP_LO  = 16'h4000;
  localparam logic [15:0] A_CMP_HI  = 16'h4004;
  localparam logic [15:0] A_TIME_LO = 16'hBFF8;
  localparam logic [15:0] A_TIME_HI = 16'hBFFC;
  localparam logic [15:0] DEC_MASK  = BASE_MASK & 16'hFFFC;
  localparam logic [15:0] PSC_LAST  = 16'(TICK_DIV - 1);

  function automatic logic hit(input logic [15:0] addr, input logic [15:0] base);
    return (addr & DEC_MASK) == (base & DEC_MASK);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

  logic [15:0] psc_cnt;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;

  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, mapped;
  logic wr;
  logic [31:0] rd_mux;

  assign sel_msip    = hit(bus_addr, A_MSIP);
  assign sel_cmp_lo  = hit(bus_addr, A_CMP_LO);
  assign sel_cmp_hi  = hit(bus_addr, A_CMP_HI);
  assign sel_time_lo = hit(bus_addr, A_TIME_LO);
  assign sel_time_hi = hit(bus_addr, A_TIME_HI);
  assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
  assign wr          = bus_req & bus_we;
  assign tick        = (psc_cnt == PSC_LAST);

  always_comb begin
    rd_mux = 32'h0;
    if (sel_msip)         rd_mux = {31'h0, msip};
    else if (sel_cmp_lo)  rd_mux = mtimecmp[31:0];
    else if (sel_cmp_hi)  rd_mux = mtimecmp[63:32];
    else if (sel_time_lo) rd_mux = mtime[31:0];
    else if (sel_time_hi) rd_mux = mtime[63:32];
  end

  // Prescaler runs freely; bus writes never disturb its phase.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) psc_cnt <= 16'h0;
    else if (tick) psc_cnt <= 16'h0;
    else psc_cnt <= psc_cnt + 16'h1;
  end

  // A write to either half takes precedence over the tick and suppresses that increment.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'h0;
    end else if (wr && sel_time_lo) begin
      mtime[31:0] <= merge(mtime[31:0], bus_wdata, bus_wstrb);
    end else if (wr && sel_time_hi) begin
      mtime[63:32] <= merge(mtime[63:32], bus_wdata, bus_wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'h1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else begin
      if (wr && sel_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus_wdata, bus_wstrb);
      if (wr && sel_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus_wdata, bus_wstrb);
      if (wr && sel_msip && bus_wstrb[0]) msip <= bus_wdata[0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= 32'h0;
      bus_err    <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      bus_rvalid <= bus_req;
      bus_rdata  <= (bus_req && !bus_we && mapped) ? rd_mux : 32'h0;
      bus_err    <= bus_req && !mapped;
      timer_irq  <= (mtime >= mtimecmp);
    end
  end

  assign sw_irq = msip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) share the bus fields;
// bus responses are checked against a scoreboard, interrupt levels inline per test.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we;
  logic [15:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        rvalid_a, err_a, tirq_a, sirq_a;
  logic        rvalid_b, err_b, tirq_b, sirq_b;
  logic [31:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) dut_a (
    .clk_in(clk), .rst_n(rst_n), .bus_req(req_a), .bus_we(we), .bus_addr(addr),
    .bus_wstrb(wstrb), .bus_wdata(wdata), .bus_rvalid(rvalid_a), .bus_rdata(rdata_a),
    .bus_err(err_a), .timer_irq(tirq_a), .sw_irq(sirq_a));

  clint_timer #(.TICK_DIV(4)) dut_b (
    .clk_in(clk), .rst_n(rst_n), .bus_req(req_b), .bus_we(we), .bus_addr(addr),
    .bus_wstrb(wstrb), .bus_wdata(wdata), .bus_rvalid(rvalid_b), .bus_rdata(rdata_b),
    .bus_err(err_b), .timer_irq(tirq_b), .sw_irq(sirq_b));

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int unsigned rcyc = 0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rcyc <= rst_n ? rcyc + 1 : 0;
  end

  // Response monitor: each accepted request must answer exactly one cycle later.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        e = q_a.pop_front();
        n_cmp++;
        if (rvalid_a !== 1'b1 || rdata_a !== e.rdata || err_a !== e.err) begin
          n_bad++;
          $display("FAIL resp_a: rvalid=%b rdata=%h err=%b, want rvalid=1 rdata=%h err=%b",
                   rvalid_a, rdata_a, err_a, e.rdata, e.err);
        end
      end else if (rvalid_a !== 1'b0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_rvalid_a: rvalid=%b, want 0", rvalid_a);
      end
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        e = q_b.pop_front();
        n_cmp++;
        if (rvalid_b !== 1'b1 || rdata_b !== e.rdata || err_b !== e.err) begin
          n_bad++;
          $display("FAIL resp_b: rvalid=%b rdata=%h err=%b, want rvalid=1 rdata=%h err=%b",
                   rvalid_b, rdata_b, err_b, e.rdata, e.err);
        end
      end else if (rvalid_b !== 1'b0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_rvalid_b: rvalid=%b, want 0", rvalid_b);
      end
    end
  end

  // Issue one request at a negedge and push its expected response; returns at the next negedge.
  task automatic op(input bit b, input logic w, input logic [15:0] a, input logic [3:0] s,
                    input logic [31:0] d, input logic [31:0] er, input logic ee);
    exp_t e;
    e.due = cyc + 1; e.rdata = er; e.err = ee;
    if (b) begin req_b = 1'b1; q_b.push_back(e); end
    else   begin req_a = 1'b1; q_a.push_back(e); end
    we = w; addr = a; wstrb = s; wdata = d;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
    addr = 16'h0; wstrb = 4'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rvalid_a, rdata_a, err_a, tirq_a, sirq_a, rvalid_b, rdata_b, err_b, tirq_b, sirq_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: a=%b/%h/%b/%b/%b b=%b/%h/%b/%b/%b, want all 0",
               rvalid_a, rdata_a, err_a, tirq_a, sirq_a, rvalid_b, rdata_b, err_b, tirq_b, sirq_b);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (tirq_a !== 1'b0 || sirq_a !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_irqs: timer=%b sw=%b, want 0 0", tirq_a, sirq_a);
    end
    op(0, 0, 16'hBFF8, 4'h0, 32'h0, 32'd10, 1'b0);
    op(0, 0, 16'hBFFC, 4'h0, 32'h0, 32'd0, 1'b0);
    op(0, 0, 16'h4000, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    op(0, 0, 16'h0000, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_msip();
    n_cmp++;
    if (sirq_a !== 1'b0) begin n_bad++; $display("FAIL msip_pre: sw_irq=%b, want 0", sirq_a); end
    op(0, 1, 16'h0000, 4'b0001, 32'h1, 32'h0, 1'b0);
    n_cmp++;
    if (sirq_a !== 1'b1) begin n_bad++; $display("FAIL msip_set: sw_irq=%b, want 1", sirq_a); end
    op(0, 0, 16'h0000, 4'h0, 32'h0, 32'h1, 1'b0);
    op(0, 1, 16'h0000, 4'b0000, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (sirq_a !== 1'b1) begin n_bad++; $display("FAIL msip_nostrb: sw_irq=%b, want 1", sirq_a); end
    op(0, 1, 16'h0000, 4'b1111, 32'hFFFF_FFFE, 32'h0, 1'b0);
    n_cmp++;
    if (sirq_a !== 1'b0) begin n_bad++; $display("FAIL msip_clr: sw_irq=%b, want 0", sirq_a); end
    op(0, 0, 16'h0000, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_timer_cmp();
    op(0, 1, 16'hBFF8, 4'hF, 32'h0, 32'h0, 1'b0);        // mtime = 0 at this edge
    op(0, 1, 16'h4004, 4'hF, 32'h0, 32'h0, 1'b0);
    op(0, 1, 16'h4000, 4'hF, 32'h20, 32'h0, 1'b0);       // mtime now 2
    repeat (30) @(negedge clk);                           // mtime now 0x20
    n_cmp++;
    if (tirq_a !== 1'b0) begin n_bad++; $display("FAIL cmp_early: timer_irq=%b, want 0", tirq_a); end
    op(0, 0, 16'hBFF8, 4'h0, 32'h0, 32'h20, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b1) begin n_bad++; $display("FAIL cmp_rise: timer_irq=%b, want 1", tirq_a); end
    op(0, 1, 16'h4004, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b1) begin n_bad++; $display("FAIL cmp_hold: timer_irq=%b, want 1", tirq_a); end
    @(negedge clk);
    n_cmp++;
    if (tirq_a !== 1'b0) begin n_bad++; $display("FAIL cmp_fall: timer_irq=%b, want 0", tirq_a); end
  endtask

  task automatic test_wrap();
    op(0, 1, 16'h4000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    op(0, 1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    op(0, 1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE, 32'h0, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b0) begin n_bad++; $display("FAIL wrap_j0: timer_irq=%b, want 0", tirq_a); end
    op(0, 0, 16'hBFF8, 4'h0, 32'h0, 32'hFFFF_FFFE, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b0) begin n_bad++; $display("FAIL wrap_j1: timer_irq=%b, want 0", tirq_a); end
    op(0, 0, 16'hBFF8, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b1) begin n_bad++; $display("FAIL wrap_pulse: timer_irq=%b, want 1", tirq_a); end
    op(0, 0, 16'hBFFC, 4'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (tirq_a !== 1'b0) begin n_bad++; $display("FAIL wrap_drop: timer_irq=%b, want 0", tirq_a); end
  endtask

  task automatic test_strobe_decode();
    op(0, 1, 16'h4004, 4'b0101, 32'hA5A5_1234, 32'h0, 1'b0);
    op(0, 0, 16'h4004, 4'h0, 32'h0, 32'hFFA5_FF34, 1'b0);
    op(0, 0, 16'h4006, 4'h0, 32'h0, 32'hFFA5_FF34, 1'b0);
    op(0, 0, 16'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
    op(0, 1, 16'h2000, 4'hF, 32'h1, 32'h0, 1'b1);
    op(0, 0, 16'h0000, 4'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (sirq_a !== 1'b0 || tirq_a !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped_write: sw=%b timer=%b, want 0 0", sirq_a, tirq_a);
    end
  endtask

  task automatic test_back_to_back();
    op(0, 1, 16'h4000, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    op(0, 0, 16'h4000, 4'h0, 32'h0, 32'h1122_3344, 1'b0);
    op(0, 1, 16'h4000, 4'b1000, 32'hAABB_CCDD, 32'h0, 1'b0);
    op(0, 0, 16'h4000, 4'h0, 32'h0, 32'hAA22_3344, 1'b0);
  endtask

  task automatic test_prescaler();
    for (int i = 0; i < 4 && ((rcyc + 1) % 4) != 0; i++) @(negedge clk);
    n_cmp++;
    if (((rcyc + 1) % 4) != 0) begin n_bad++; $display("FAIL psc_align: rcyc=%0d", rcyc); end
    op(1, 1, 16'hBFF8, 4'hF, 32'd5, 32'h0, 1'b0);        // lands on a tick edge
    op(1, 0, 16'hBFF8, 4'h0, 32'h0, 32'd5, 1'b0);
    op(1, 0, 16'hBFF8, 4'h0, 32'h0, 32'd5, 1'b0);
    op(1, 0, 16'hBFF8, 4'h0, 32'h0, 32'd5, 1'b0);
    op(1, 0, 16'hBFF8, 4'h0, 32'h0, 32'd5, 1'b0);
    op(1, 0, 16'hBFF8, 4'h0, 32'h0, 32'd6, 1'b0);
    op(1, 0, 16'hBFFC, 4'h0, 32'h0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_abort();
    req_a = 1'b1; we = 1'b0; addr = 16'hBFF8; wstrb = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    n_cmp++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 || sirq_a !== 1'b0 || tirq_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_reset: rvalid=%b rdata=%h sw=%b timer=%b, want 0", rvalid_a, rdata_a, sirq_a, tirq_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid_a !== 1'b0) begin n_bad++; $display("FAIL abort_rvalid: cycle %0d rvalid=%b, want 0", i, rvalid_a); end
    end
    op(0, 0, 16'hBFF8, 4'h0, 32'h0, 32'd3, 1'b0);
    op(0, 0, 16'h4004, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer_cmp();
    test_wrap();
    test_strobe_decode();
    test_back_to_back();
    test_prescaler();
    test_reset_abort();
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_bad++;
      $display("FAIL pending_resp: a=%0d b=%0d outstanding, want 0 0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor; drives the timer_irq and sw_irq inputs of the core's CSR block.
- Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a 1-bit msip.
- All three are memory-mapped behind a simple request/response data-bus port.
- Generates the machine timer interrupt level (mtime >= mtimecmp) and the machine software interrupt level (msip).

Parameters:
- TICK_DIV, 1: clk_in cycles per mtime increment; legal range 1..65535.
- BASE_MASK, 16'hFFFF: address bits compared for decode; bits outside the mask are ignored.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bus_req  input  1  request valid; accepted the same cycle (no back-pressure).
- bus_we  input  1  1 = write, 0 = read.
- bus_addr  input  16  byte address, word aligned (bits [1:0] ignored).
- bus_wstrb  input  4  byte enables for writes.
- bus_wdata  input  32  write data.
- bus_rvalid  output  1  response valid, exactly 1 cycle after each accepted request.
- bus_rdata  output  32  read data; 0 for writes and errors.
- bus_err  output  1  qualifies bus_rvalid; unmapped address.
- timer_irq  output  1  machine timer interrupt level to CSR.
- sw_irq  output  1  machine software interrupt level to CSR.

Behaviour:
- Reset (async assert, sync-released by the clock) drives every state and output to a known value:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; prescaler count = 0.
  - bus_rvalid = 0; bus_rdata = 0; bus_err = 0; timer_irq = 0; sw_irq = 0.
- Reset mid-operation aborts any pending response; no rvalid is issued after reset deasserts for a request accepted before reset.
- Register map (word addresses):
  - 0x0000 msip: bit0 R/W; bits[31:1] read 0, writes ignored.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other address: no state change, bus_rdata = 0, bus_err = 1.
- Bus timing:
  - Request sampled on the cycle bus_req = 1.
  - Write takes effect at that clock edge; registers show the new value from the next cycle.
  - bus_rvalid pulses 1 cycle later.
  - Read data is the register value before any same-cycle update (pre-increment mtime).
  - Back-to-back requests on every cycle are legal and yield back-to-back rvalid pulses.
  - bus_wstrb applies per byte; with bus_wstrb = 0 the write is still acknowledged but nothing changes.
- Prescaler and mtime increment:
  - The prescaler counts 0..TICK_DIV-1; tick = 1 when count == TICK_DIV-1, then it wraps to 0.
  - When TICK_DIV = 1, tick = 1 every cycle.
  - On tick, mtime <= mtime + 1 as full 64-bit unsigned; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Simultaneous mtime write and tick: the write wins for the written half. That cycle:
  - a low write gives mtime = {old hi, merged lo};
  - a high write gives mtime = {merged hi, old lo};
  - no increment occurs.
  - The prescaler is never reset by writes.
- timer_irq:
  - Registered; timer_irq <= (mtime >= mtimecmp), 64-bit unsigned, evaluated on current register values.
  - It therefore lags the compare condition by 1 cycle.
  - Level output; it stays high until mtimecmp is raised above mtime or mtime wraps below mtimecmp.
  - Writing the mtimecmp halves separately may glitch the level for 1 cycle; software writes hi = all-ones first.
- sw_irq:
  - sw_irq = msip (registered, directly from the flop).
  - Rises the cycle after the write edge and clears the cycle after msip is written with 0.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV = 1 -> mtime reads 10 ± the 1-cycle read offset (exact: value at sample edge); timer_irq = 0; sw_irq = 0.
- Write msip = 1 (wstrb = 4'b0001) -> rvalid 1 cycle later with rdata = 0 and err = 0; sw_irq = 1 the following cycle; write 0 -> sw_irq falls 1 cycle later.
- mtimecmp = 0x0000_0000_0000_0020, TICK_DIV = 1 -> timer_irq rises exactly 1 cycle after mtime reaches 0x20; writing mtimecmp_hi = 0xFFFF_FFFF deasserts it 1 cycle after the next compare.
- Write mtime = 0xFFFF_FFFF_FFFF_FFFE via both halves with mtimecmp = 0xFFFF_FFFF_FFFF_FFFF -> timer_irq pulses for the all-ones value, then mtime wraps to 0 and timer_irq drops.
- TICK_DIV = 4; write mtime_lo = 5 on a tick cycle -> mtime = 5 (no increment); next increment occurs exactly 4 cycles after the previous tick.
- Read 0x1000 and read-after-write at 0x4004 -> 0x1000 gives rvalid, err = 1, rdata = 0; 0x4004 returns the written word masked by strobes; reset asserted between request and rvalid gives no rvalid.
